// File: rtl/ascon_output_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ascon_pkg
// Description : Shared types and constants for the ASCON output serializer.
//               Holds the serializer state encoding, byte counts per word and
//               per tag, and a helper that extracts one tag byte MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CIPHER = 2'd1,
    S_TAG    = 2'd2,
    S_DONE   = 2'd3
  } ser_state_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int TAG_BYTES      = 16;

  // Byte idx of the tag, counted from the most significant end (idx 0 = tag[127:120]).
  function automatic logic [7:0] tag_byte(input logic [127:0] tag, input logic [3:0] idx);
    logic [127:0] shifted;
    shifted = tag << {idx, 3'b000};
    return shifted[127:120];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_output_serializer_if.sv
`default_nettype none
// ============================================================================
// Interface   : ascon_output_serializer_if
// Description : Bundles the cipher/tag input side and the byte-stream output
//               side of the serializer.
//               slave  : serializer view (consumes cipher/tag, drives bytes)
//               master : environment view (drives cipher/tag, consumes bytes)
// Revision    : 1.0 - initial release
// ============================================================================
interface ascon_output_serializer_if;
  logic         cipher_valid_i;
  logic [63:0]  cipher_i;
  logic         end_i;
  logic [127:0] tag_i;
  logic         byte_ready_i;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         last_o;
  logic         done_o;
  logic         busy_o;
  logic         overflow_o;

  modport slave (
    input  cipher_valid_i, cipher_i, end_i, tag_i, byte_ready_i,
    output byte_o, byte_valid_o, last_o, done_o, busy_o, overflow_o
  );

  modport master (
    output cipher_valid_i, cipher_i, end_i, tag_i, byte_ready_i,
    input  byte_o, byte_valid_o, last_o, done_o, busy_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/ascon_output_serializer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ascon_word_fifo
// Description : 64-bit synchronous FIFO, FIFO_DEPTH entries (power of 2).
//               A push on a full FIFO is accepted only when a pop happens in
//               the same cycle. data_o shows the head entry (show-ahead).
// Ports       : clock_i, resetb_i (async active-low), push_i/data_i,
//               pop_i/data_o, full_o, empty_o, count_o
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_word_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                          clock_i,
  input  wire logic                          resetb_i,
  input  wire logic                          push_i,
  input  wire logic [63:0]                   data_i,
  input  wire logic                          pop_i,
  output logic [63:0]                        data_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(FIFO_DEPTH):0]        count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule
`default_nettype wire

// File: rtl/ascon_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ascon_output_serializer
// Description : Buffers 64-bit cipher words and the 128-bit tag from the
//               ASCON core and streams one message as bytes (MSB first):
//               cipher bytes, then 16 tag bytes, with valid/ready handshake.
// Ports       : clock_i, resetb_i (async active-low),
//               bus (slave): cipher_valid_i/cipher_i, end_i/tag_i,
//               byte_ready_i, byte_o, byte_valid_o, last_o, done_o,
//               busy_o, overflow_o
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_output_serializer
  import ascon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                clock_i,
  input  wire logic                resetb_i,
  ascon_output_serializer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ser_state_t    state_q, state_d;
  logic [63:0]   shift_q, shift_d;
  logic [127:0]  tag_q, tag_d;
  logic          tag_pending_q, tag_pending_d;
  logic [CW-1:0] wbt_q, wbt_d;          // words still in the FIFO that precede the tag
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          fifo_push, fifo_push_ok, fifo_pop, fifo_full, fifo_empty;
  logic [63:0]   fifo_data;
  logic [CW-1:0] fifo_count;
  logic          bypass, accept, tag_first, fifo_nonempty_next;

  ascon_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .push_i   (fifo_push),
    .data_i   (bus.cipher_i),
    .pop_i    (fifo_pop),
    .data_o   (fifo_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    tag_d         = tag_q;
    tag_pending_d = tag_pending_q;
    wbt_d         = wbt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_d        = byte_q;
    byte_valid_d  = byte_valid_q;
    last_d        = last_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
    fifo_pop      = 1'b0;
    bypass        = 1'b0;
    accept        = byte_valid_q && bus.byte_ready_i;
    tag_first     = tag_pending_q && (wbt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (tag_first) begin
          state_d = S_TAG; byte_cnt_d = '0; byte_valid_d = 1'b1;
          byte_d  = tag_byte(tag_q, 4'd0); last_d = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_CIPHER; byte_cnt_d = '0; byte_valid_d = 1'b1;
          byte_d   = fifo_data[63:56]; shift_d = {fifo_data[55:0], 8'h00};
        end else if (bus.cipher_valid_i) begin
          // Empty FIFO: take the word straight into the shift register so the
          // first byte is valid in the cycle right after the push.
          bypass  = 1'b1;
          state_d = S_CIPHER; byte_cnt_d = '0; byte_valid_d = 1'b1;
          byte_d  = bus.cipher_i[63:56]; shift_d = {bus.cipher_i[55:0], 8'h00};
        end
      end
      S_CIPHER: begin
        if (accept) begin
          if (byte_cnt_q == 4'(BYTES_PER_WORD - 1)) begin
            if (tag_first) begin
              state_d = S_TAG; byte_cnt_d = '0;
              byte_d  = tag_byte(tag_q, 4'd0); last_d = 1'b0;
            end else if (!fifo_empty) begin
              fifo_pop   = 1'b1; byte_cnt_d = '0;
              byte_d     = fifo_data[63:56]; shift_d = {fifo_data[55:0], 8'h00};
            end else begin
              state_d = S_IDLE; byte_valid_d = 1'b0; byte_d = '0;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            byte_d     = shift_q[63:56];
            shift_d    = {shift_q[55:0], 8'h00};
          end
        end
      end
      S_TAG: begin
        if (accept) begin
          if (byte_cnt_q == 4'(TAG_BYTES - 1)) begin
            state_d = S_DONE; byte_valid_d = 1'b0; byte_d = '0; last_d = 1'b0;
            done_d  = 1'b1; tag_pending_d = 1'b0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            byte_d     = tag_byte(tag_q, byte_cnt_q + 4'd1);
            last_d     = (byte_cnt_q + 4'd1 == 4'(TAG_BYTES - 1));
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    fifo_push    = bus.cipher_valid_i && !bypass;
    fifo_push_ok = fifo_push && (!fifo_full || fifo_pop);
    if (fifo_push && !fifo_push_ok) overflow_d = 1'b1;

    // A popped word is committed to the shift register and will be emitted
    // before anything else, so it stops counting towards the tag.
    if (fifo_pop && (wbt_q != '0)) wbt_d = wbt_q - CW'(1);

    if (bus.end_i) begin
      if (tag_pending_q) begin
        overflow_d = 1'b1;
      end else begin
        tag_d         = bus.tag_i;
        tag_pending_d = 1'b1;
        wbt_d         = fifo_count + CW'(fifo_push_ok) - CW'(fifo_pop);
      end
    end

    fifo_nonempty_next = fifo_push_ok || (fifo_count > CW'(1)) ||
                         ((fifo_count == CW'(1)) && !fifo_pop);
    busy_d = (state_d != S_IDLE) || tag_pending_d || fifo_nonempty_next;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      tag_q         <= '0;
      tag_pending_q <= 1'b0;
      wbt_q         <= '0;
      byte_cnt_q    <= '0;
      byte_q        <= '0;
      byte_valid_q  <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      tag_q         <= tag_d;
      tag_pending_q <= tag_pending_d;
      wbt_q         <= wbt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_q        <= byte_d;
      byte_valid_q  <= byte_valid_d;
      last_q        <= last_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.byte_o       = byte_q;
  assign bus.byte_valid_o = byte_valid_q;
  assign bus.last_o       = last_q;
  assign bus.done_o       = done_q;
  assign bus.busy_o       = busy_q;
  assign bus.overflow_o   = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_ascon_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_output_serializer
// Description : Scoreboard bench for the ASCON output serializer. Stimulus
//               pushes expected {last, byte} entries into a queue; a monitor
//               pops and compares on every accepted byte, checks stalled
//               bytes stay stable and that done_o follows the last byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_output_serializer;
  logic clock_i = 1'b0;
  logic resetb_i;
  always #5 clock_i = ~clock_i;

  ascon_output_serializer_if bus();

  ascon_output_serializer #(.FIFO_DEPTH(4)) dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  int ready_mode = 1;   // 0 low, 1 high, 2 random ~30%, 3 high until acc_limit
  int acc_cnt    = 0;
  int acc_limit  = 0;

  localparam logic [63:0]  W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0]  W2 = 64'hFEDCBA9876543210;
  localparam logic [127:0] T1 = 128'h00112233445566778899AABBCCDDEEFF;

  // ---------------- ready driver ----------------
  initial begin
    bus.byte_ready_i = 1'b0;
    forever begin
      @(posedge clock_i); #1;
      case (ready_mode)
        0:       bus.byte_ready_i = 1'b0;
        1:       bus.byte_ready_i = 1'b1;
        2:       bus.byte_ready_i = ($urandom_range(0, 9) < 3);
        default: bus.byte_ready_i = (acc_cnt < acc_limit);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = '0;
  logic       prev_last  = 1'b0;
  logic       exp_done   = 1'b0;
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clock_i);
      if (!resetb_i) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        if (exp_done) begin
          total++;
          if (bus.done_o !== 1'b1) begin
            bad++; $display("FAIL done_pulse: done_o=%0b required 1", bus.done_o);
          end
          exp_done = 1'b0;
        end else if (bus.done_o === 1'b1) begin
          total++; bad++;
          $display("FAIL spurious_done: done_o=1 required 0");
        end
        if (prev_stall) begin
          total++;
          if (bus.byte_valid_o !== 1'b1 || bus.byte_o !== prev_byte || bus.last_o !== prev_last) begin
            bad++;
            $display("FAIL stall_hold: valid=%0b byte=%02h last=%0b required valid=1 byte=%02h last=%0b",
                     bus.byte_valid_o, bus.byte_o, bus.last_o, prev_byte, prev_last);
          end
        end
        if (bus.byte_valid_o === 1'b1 && bus.byte_ready_i === 1'b1) begin
          acc_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_byte: byte=%02h last=%0b required none", bus.byte_o, bus.last_o);
          end else begin
            e = exp_q.pop_front();
            if ({bus.last_o, bus.byte_o} !== e) begin
              bad++;
              $display("FAIL byte: last=%0b byte=%02h required last=%0b byte=%02h",
                       bus.last_o, bus.byte_o, e[8], e[7:0]);
            end
          end
          if (bus.last_o === 1'b1) exp_done = 1'b1;
        end
        prev_stall = (bus.byte_valid_o === 1'b1) && (bus.byte_ready_i !== 1'b1);
        prev_byte  = bus.byte_o;
        prev_last  = bus.last_o;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock_i); #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic exp_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, w[63-8*i -: 8]});
  endtask

  task automatic exp_tag(input logic [127:0] t);
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), t[127-8*i -: 8]});
  endtask

  task automatic push_word(input logic [63:0] w);
    bus.cipher_valid_i = 1'b1; bus.cipher_i = w;
    tick();
    bus.cipher_valid_i = 1'b0;
  endtask

  task automatic push_end(input logic [127:0] t);
    bus.end_i = 1'b1; bus.tag_i = t;
    tick();
    bus.end_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < budget) begin
      tick(); n++;
    end
    check("drain", {127'd0, (exp_q.size() == 0 && !bus.busy_o)}, 128'd1);
    tick();
  endtask

  task automatic do_reset();
    resetb_i = 1'b0;
    tick(); tick();
    exp_q.delete();
    resetb_i = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] t6;
    bus.cipher_valid_i = 1'b0; bus.cipher_i = '0;
    bus.end_i = 1'b0; bus.tag_i = '0;
    resetb_i = 1'b0;
    tick(); tick();
    check("rst_valid",    {127'd0, bus.byte_valid_o}, 128'd0);
    check("rst_byte",     {120'd0, bus.byte_o},       128'd0);
    check("rst_last",     {127'd0, bus.last_o},       128'd0);
    check("rst_done",     {127'd0, bus.done_o},       128'd0);
    check("rst_busy",     {127'd0, bus.busy_o},       128'd0);
    check("rst_overflow", {127'd0, bus.overflow_o},   128'd0);
    resetb_i = 1'b1;
    tick();

    // 1. basic message, plus first-byte latency
    exp_word(W1); exp_word(W2); exp_tag(T1);
    push_word(W1);
    check("latency_valid", {127'd0, bus.byte_valid_o}, 128'd1);
    check("latency_byte",  {120'd0, bus.byte_o},       128'h01);
    push_word(W2);
    push_end(T1);
    wait_drain(300);
    check("basic_overflow", {127'd0, bus.overflow_o}, 128'd0);

    // 2. back-pressure
    ready_mode = 2;
    exp_word(W1); exp_word(W2); exp_tag(T1);
    push_word(W1); push_word(W2); push_end(T1);
    wait_drain(3000);
    check("bp_overflow", {127'd0, bus.overflow_o}, 128'd0);
    ready_mode = 1;

    // 3a. word overflow: 6 back-to-back words, sink stalled
    ready_mode = 0; tick(); tick();
    for (int i = 0; i < 6; i++) begin
      bus.cipher_valid_i = 1'b1; bus.cipher_i = {8{8'h10 + 8'(i)}};
      if (i < 5) exp_word({8{8'h10 + 8'(i)}});
      tick();
    end
    bus.cipher_valid_i = 1'b0;
    check("word_overflow", {127'd0, bus.overflow_o}, 128'd1);
    exp_tag(~T1);
    push_end(~T1);
    push_end(T1);         // dropped: tag already pending
    ready_mode = 1;
    wait_drain(500);
    check("overflow_sticky", {127'd0, bus.overflow_o}, 128'd1);
    do_reset();
    check("overflow_cleared", {127'd0, bus.overflow_o}, 128'd0);

    // 3b. tag overflow alone
    ready_mode = 0; tick(); tick();
    exp_tag(T1);
    push_end(T1);
    check("no_overflow_yet", {127'd0, bus.overflow_o}, 128'd0);
    push_end(~T1);
    check("tag_overflow", {127'd0, bus.overflow_o}, 128'd1);
    ready_mode = 1;
    wait_drain(300);
    do_reset();

    // 4. ordering across messages
    ready_mode = 0; tick(); tick();
    exp_word(W1); exp_tag(T1); exp_word(W2);
    push_word(W1); push_end(T1); push_word(W2);
    ready_mode = 1;
    wait_drain(300);
    exp_tag(~T1);
    push_end(~T1);
    wait_drain(300);

    // 5a. word and end in the same cycle
    exp_word(W2); exp_tag(T1);
    bus.cipher_valid_i = 1'b1; bus.cipher_i = W2;
    bus.end_i = 1'b1; bus.tag_i = T1;
    tick();
    bus.cipher_valid_i = 1'b0; bus.end_i = 1'b0;
    wait_drain(300);

    // 5b. tag-only message
    exp_tag(~T1);
    push_end(~T1);
    wait_drain(300);

    // 6. reset during tag byte 5
    t6 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    acc_limit  = acc_cnt + 5;
    ready_mode = 3;
    exp_tag(t6);
    push_end(t6);
    for (int n = 0; n < 100 && acc_cnt < acc_limit; n++) tick();
    tick(); tick();
    check("mid_tag_byte", {120'd0, bus.byte_o},       128'hA5);
    check("mid_tag_valid", {127'd0, bus.byte_valid_o}, 128'd1);
    #2 resetb_i = 1'b0;
    #1;
    check("abort_valid", {127'd0, bus.byte_valid_o}, 128'd0);
    check("abort_byte",  {120'd0, bus.byte_o},       128'd0);
    check("abort_busy",  {127'd0, bus.busy_o},       128'd0);
    check("abort_done",  {127'd0, bus.done_o},       128'd0);
    exp_q.delete();
    tick(); tick();
    ready_mode = 1;
    resetb_i = 1'b1;
    tick(); tick(); tick();
    exp_word(W1); exp_word(W2); exp_tag(T1);
    push_word(W1); push_word(W2); push_end(T1);
    wait_drain(300);
    check("final_overflow", {127'd0, bus.overflow_o}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
